hex_count_driver: RTL and testbench

- Upstream stage of the per-digit 7-segment decoders.
- A rate divider generates a one-cycle tick every DIV_COUNT clocks. On each tick, a 16-bit hex counter steps up or down.
- The counter drives four 4-bit digit outputs, one per HEX decoder instance.
- Supports synchronous parallel load, pause, and a display-freeze snapshot so the value can be read while the counter keeps running.

---
 rtl/hex_count_driver.sv | 86 ++++++++
 tb/tb_hex_count_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_count_driver.sv
// Rate-divided 16-bit up/down hex counter feeding four 7-segment digit decoders.
// All outputs are registered (one-cycle latency); load wins over a coincident tick.
module hex_count_driver #(
  parameter int DIV_COUNT = 50000000,
  parameter int DIV_W     = 26
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        freeze,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        tick,
  output logic        wrap
);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_COUNT - 1);

  logic [DIV_W-1:0] div_q;
  logic [15:0]      value_q;
  logic [15:0]      digits_q;
  logic             tick_q;
  logic             wrap_q;

  logic             tick_int;
  logic [15:0]      value_step;
  logic             step_wraps;

  assign tick_int   = enable && (div_q == '0);
  assign value_step = up_down ? (value_q + 16'd1) : (value_q - 16'd1);
  assign step_wraps = up_down ? (value_q == 16'hFFFF) : (value_q == 16'h0000);

  // Divider, counter and step-event flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= DIV_RELOAD;
      value_q <= 16'h0000;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (load) begin
      // A tick landing on the load cycle is dropped entirely.
      div_q   <= DIV_RELOAD;
      value_q <= load_value;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      if (enable) begin
        if (div_q == '0) begin
          div_q <= DIV_RELOAD;
        end else begin
          div_q <= div_q - 1'b1;
        end
      end
      if (tick_int) begin
        value_q <= value_step;
        tick_q  <= 1'b1;
        wrap_q  <= step_wraps;
      end else begin
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end
  end

  // Display snapshot; holds while frozen so the counter can keep running underneath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits_q <= 16'h0000;
    end else if (!freeze) begin
      digits_q <= value_q;
    end
  end

  assign digit0 = digits_q[3:0];
  assign digit1 = digits_q[7:4];
  assign digit2 = digits_q[11:8];
  assign digit3 = digits_q[15:12];
  assign tick   = tick_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_hex_count_driver.sv
// Directed bench for hex_count_driver: one instance with a 4-cycle divider, one with a 1-cycle divider.
module tb_hex_count_driver;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic        freeze;

  logic [3:0]  a_d0, a_d1, a_d2, a_d3;
  logic        a_tick, a_wrap;
  logic [3:0]  b_d0, b_d1, b_d2, b_d3;
  logic        b_tick, b_wrap;

  logic [15:0] a_dig, b_dig;
  assign a_dig = {a_d3, a_d2, a_d1, a_d0};
  assign b_dig = {b_d3, b_d2, b_d1, b_d0};

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int wrap_cnt = 0;
  int wrap_bad = 0;
  logic [11:0] tick_hist;

  always #5 clk = ~clk;

  hex_count_driver #(.DIV_COUNT(4), .DIV_W(3)) u_div4 (
    .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .freeze(freeze),
    .digit0(a_d0), .digit1(a_d1), .digit2(a_d2), .digit3(a_d3),
    .tick(a_tick), .wrap(a_wrap)
  );

  hex_count_driver #(.DIV_COUNT(1), .DIV_W(1)) u_div1 (
    .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .freeze(freeze),
    .digit0(b_d0), .digit1(b_d1), .digit2(b_d2), .digit3(b_d3),
    .tick(b_tick), .wrap(b_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling the 4-divider instance on each falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_tick === 1'b1) tick_cnt++;
      if (a_wrap === 1'b1) wrap_cnt++;
      if (a_wrap === 1'b1 && a_tick !== 1'b1) wrap_bad++;
    end
  endtask

  task automatic clr();
    tick_cnt = 0;
    wrap_cnt = 0;
  endtask

  // One-cycle load strobe; returns on the falling edge after the loading clock edge.
  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    @(negedge clk);
    load       = 1'b0;
    clr();
  endtask

  initial begin
    resetn     = 1'b0;
    enable     = 1'b0;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = 16'h0000;
    freeze     = 1'b0;
    tick_hist  = '0;
    repeat (2) @(negedge clk);

    chk("reset_digits", {16'h0, a_dig}, 32'h0000);
    chk("reset_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h0);
    chk("reset_div1_out", {14'h0, b_dig, b_tick, b_wrap}, 32'h0);

    // Up count from reset: ticks after the 4th, 8th and 12th edges
    resetn  = 1'b1;
    enable  = 1'b1;
    up_down = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      tick_hist[c] = a_tick;
    end
    chk("tick_every_4", {20'h0, tick_hist}, 32'h0000_0888);
    cyc(1);
    chk("three_ticks_digits", {16'h0, a_dig}, 32'h0003);
    cyc(3);
    chk("pre_reset_tick", {31'h0, a_tick}, 32'h1);

    // Asynchronous reset mid-count clears outputs without a clock edge
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_digits", {16'h0, a_dig}, 32'h0000);
    chk("async_reset_tick", {30'h0, a_tick, a_wrap}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Up wrap: FFFE -> FFFF -> 0000
    do_load(16'hFFFE);
    cyc(4);
    chk("up_step1_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h2);
    cyc(1);
    chk("up_step1_digits", {16'h0, a_dig}, 32'hFFFF);
    cyc(3);
    chk("up_wrap_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h3);
    cyc(1);
    chk("up_wrap_digits", {16'h0, a_dig}, 32'h0000);
    chk("up_wrap_once", wrap_cnt, 32'd1);

    // Down wrap then direction change between ticks
    up_down = 1'b0;
    do_load(16'h0001);
    cyc(4);
    chk("down_step1_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h2);
    cyc(1);
    chk("down_step1_digits", {16'h0, a_dig}, 32'h0000);
    cyc(3);
    chk("down_wrap_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h3);
    cyc(1);
    chk("down_wrap_digits", {16'h0, a_dig}, 32'hFFFF);
    up_down = 1'b1;
    cyc(3);
    chk("dir_change_tick_wrap", {30'h0, a_tick, a_wrap}, 32'h3);
    cyc(1);
    chk("dir_change_digits", {16'h0, a_dig}, 32'h0000);

    // Load on the cycle the divider reaches zero
    cyc(2);
    do_load(16'h1234);
    chk("collision_no_tick", {30'h0, a_tick, a_wrap}, 32'h0);
    cyc(1);
    chk("collision_digits", {16'h0, a_dig}, 32'h1234);
    cyc(3);
    chk("post_collision_tick", {31'h0, a_tick}, 32'h1);
    chk("post_collision_tick_cnt", tick_cnt, 32'd1);
    cyc(1);
    chk("post_collision_digits", {16'h0, a_dig}, 32'h1235);

    // Pause: divider holds at 2 and resumes from there
    enable = 1'b0;
    clr();
    cyc(10);
    chk("pause_no_tick", tick_cnt, 32'd0);
    chk("pause_digits", {16'h0, a_dig}, 32'h1235);
    enable = 1'b1;
    cyc(2);
    chk("resume_no_early_tick", tick_cnt, 32'd0);
    cyc(1);
    chk("resume_tick", {31'h0, a_tick}, 32'h1);
    cyc(1);
    chk("resume_digits", {16'h0, a_dig}, 32'h1236);

    // Freeze: digits hold while the counter keeps ticking
    do_load(16'h0040);
    cyc(1);
    chk("freeze_start_digits", {16'h0, a_dig}, 32'h0040);
    freeze = 1'b1;
    clr();
    cyc(20);
    chk("freeze_held_digits", {16'h0, a_dig}, 32'h0040);
    chk("freeze_tick_cnt", tick_cnt, 32'd5);
    do_load(16'h0200);
    cyc(10);
    chk("freeze_load_hidden", {16'h0, a_dig}, 32'h0040);
    chk("freeze_load_tick_cnt", tick_cnt, 32'd2);
    freeze = 1'b0;
    cyc(1);
    chk("unfreeze_digits", {16'h0, a_dig}, 32'h0202);

    // Divide-by-one instance ticks every enabled cycle
    do_load(16'h0010);
    chk("div1_load_no_tick", {31'h0, b_tick}, 32'h0);
    cyc(1);
    chk("div1_c1", {15'h0, b_tick, b_dig}, 32'h1_0010);
    cyc(1);
    chk("div1_c2", {15'h0, b_tick, b_dig}, 32'h1_0011);
    cyc(1);
    chk("div1_c3", {15'h0, b_tick, b_dig}, 32'h1_0012);
    enable = 1'b0;
    cyc(1);
    chk("div1_disabled", {15'h0, b_tick, b_dig}, 32'h0_0013);

    chk("wrap_only_with_tick", wrap_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
